multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Clock and reset SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter MEM_WAIT, default 0, range 0..15: extra cycles mem_cmd is held per memory access.
REQ-003 Parameter BRANCH_EN, default 1: 1 enables branch opcodes 001/010; 0 makes them illegal.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 opcode  in  3  instruction-register opcode field.
REQ-007 op  in  2  instruction-register op field.
REQ-008 cond  in  3  branch condition field.
REQ-009 status  in  3  {N,V,Z} status flags.
REQ-010 vsel  out  4  register-file write mux: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata.
REQ-011 nsel  out  3  one-hot register select: 001 Rm, 010 Rd, 100 Rn.
REQ-012 mem_cmd  out  2  memory command: 00 none, 01 read, 11 write.
REQ-013 write, loada, loadb, asel, bsel, loadc, loads  out  1 each  datapath controls.
REQ-014 load_pc, reset_pc, load_ir, addr_sel, load_addr  out  1 each  fetch/address controls.
REQ-015 pc_sel  out  2  next-PC source: 00 PC+1, 01 PC+1+sximm8, 10 datapath_out.
REQ-016 halted  out  1  high in HALT.
REQ-017 illegal  out  1  high in HALT when HALT was entered from an undefined encoding.
REQ-018 state  out  5  current state code, for debug.

Function
REQ-019 Outputs SHALL be Moore outputs decoded from the registered state only; unlisted controls are 0 and don't-care fields are driven 0.
REQ-020 States: RST, IF1, IF2, UPD_PC, DECODE, GET_A, GET_B, ALU, WB, CMP, MOV_IMM, MOV_B, MOV_C, MOV_WB, ADDR, LATCH_A, LD_MEM, LD_WB, ST_B, ST_C, ST_MEM, BR, BL_LINK, BX_B, BX_C, BX_PC, HALT.
REQ-021 Fetch: RST (reset_pc=1, load_pc=1) -> IF1 (addr_sel=1, mem_cmd=01) -> IF2 (addr_sel=1, mem_cmd=01, load_ir=1) -> UPD_PC (load_pc=1, pc_sel=00) -> DECODE.
REQ-022 Memory wait: IF1, LD_MEM and ST_MEM SHALL each last exactly MEM_WAIT+1 cycles, with mem_cmd held constant throughout.
REQ-023 DECODE routing: 101/011/100 -> GET_A; 110 with op=10 -> MOV_IMM; 110 with op=00 -> MOV_B; 111 -> HALT.
REQ-024 DECODE routing with BRANCH_EN=1: 001 with op=00 -> BR; 010 with op=11 -> BL_LINK; 010 with op=00 -> BX_B.
REQ-025 Any other encoding in DECODE SHALL go to HALT with illegal=1.
REQ-026 ALU path: GET_A (nsel=100, loada) -> GET_B (nsel=001, loadb) -> ALU (loadc, loads), or -> CMP (loads only) when op=01.
REQ-027 ALU path completion: ALU -> WB (vsel=0001, nsel=010, write) -> IF1; CMP -> IF1.
REQ-028 Load/store address: GET_A -> ADDR (bsel=1, loadc) -> LATCH_A (load_addr).
REQ-029 Load path: LATCH_A -> LD_MEM (mem_cmd=01, addr_sel=0) -> LD_WB (vsel=1000, nsel=010, write, mem_cmd=01) -> IF1.
REQ-030 Store path: LATCH_A -> ST_B (nsel=010, loadb) -> ST_C (asel=1, loadc) -> ST_MEM (mem_cmd=11) -> IF1.
REQ-031 Move paths: MOV_IMM (vsel=0100, nsel=100, write) -> IF1; MOV_B (nsel=001, loadb) -> MOV_C (asel=1, loadc) -> MOV_WB (vsel=0001, nsel=010, write) -> IF1.
REQ-032 Branch conditions: 000 always; 001 Z; 010 !Z; 011 N!=V; 100 (N!=V)|Z; 101..111 illegal -> HALT.
REQ-033 BR SHALL assert load_pc with pc_sel=01 only when the condition is true; BR then goes to IF1.
REQ-034 BL_LINK SHALL assert vsel=0010, nsel=100 (R7 via Rn field), write, load_pc and pc_sel=01, then go to IF1.
REQ-035 BX: BX_B (nsel=010, loadb) -> BX_C (asel=1, loadc) -> BX_PC (load_pc, pc_sel=10) -> IF1.
REQ-036 HALT SHALL be absorbing; only reset_n exits it.

Reset
REQ-037 reset_n low SHALL immediately force state=RST, clear the wait counter and illegal, and make every output 0 except reset_pc=1 and load_pc=1.
REQ-038 Reset asserted mid-wait or mid-instruction SHALL abandon the access; the first cycle after release SHALL be RST.

Structure
REQ-039 A shared package SHALL hold the state encodings, mem_cmd codes, vsel codes, nsel codes, pc_sel codes and cond codes.
REQ-040 A sub-module wait_counter (4-bit, load/decrement, done flag) SHALL implement the memory wait; the state register stays in this module.

Verification
REQ-041 Reset then MEM_WAIT=2: IF1 SHALL hold mem_cmd=01 for 3 cycles, with load_ir asserted in the following IF2 cycle.
REQ-042 ADD (opcode 101, op 00): sequence SHALL be GET_A, GET_B, ALU, WB, with write=1 and nsel=010 only in WB; CMP (op 01) SHALL never assert write.
REQ-043 BEQ with Z=1: BR SHALL assert load_pc with pc_sel=01; with Z=0, load_pc SHALL stay 0 and the next state SHALL be IF1.
REQ-044 STR (opcode 100): mem_cmd=11 SHALL appear only in ST_MEM, for MEM_WAIT+1 cycles, with addr_sel=0.
REQ-045 BRANCH_EN=0 with opcode 001: DECODE -> HALT, halted=1, illegal=1, held for 20 cycles; reset_n pulse -> RST, illegal=0.
REQ-046 reset_n dropped during LD_MEM wait: state SHALL be RST asynchronously, with write never asserted.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: state codes, datapath
// select codes, opcodes, branch conditions and the control-word layout.
package multicycle_controller_pkg;

    typedef enum logic [4:0] {
        RST     = 5'd0,
        IF1     = 5'd1,
        IF2     = 5'd2,
        UPD_PC  = 5'd3,
        DECODE  = 5'd4,
        GET_A   = 5'd5,
        GET_B   = 5'd6,
        ALU     = 5'd7,
        WB      = 5'd8,
        CMP     = 5'd9,
        MOV_IMM = 5'd10,
        MOV_B   = 5'd11,
        MOV_C   = 5'd12,
        MOV_WB  = 5'd13,
        ADDR    = 5'd14,
        LATCH_A = 5'd15,
        LD_MEM  = 5'd16,
        LD_WB   = 5'd17,
        ST_B    = 5'd18,
        ST_C    = 5'd19,
        ST_MEM  = 5'd20,
        BR      = 5'd21,
        BL_LINK = 5'd22,
        BX_B    = 5'd23,
        BX_C    = 5'd24,
        BX_PC   = 5'd25,
        HALT    = 5'd26
    } state_t;

    // Memory commands
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b11;

    // Register-file write source
    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    // One-hot register select
    localparam logic [2:0] NSEL_RM = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RN = 3'b100;

    // Next-PC source
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    // Branch conditions
    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    // Opcodes
    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_BL   = 3'b010;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Full registered control word
    typedef struct packed {
        logic [3:0] vsel;
        logic [2:0] nsel;
        logic [1:0] mem_cmd;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic       load_pc;
        logic       reset_pc;
        logic       load_ir;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] pc_sel;
        logic       halted;
    } ctrl_t;

    // States whose length is stretched by the memory wait counter
    function automatic logic is_wait_state(state_t s);
        return (s == IF1) || (s == LD_MEM) || (s == ST_MEM);
    endfunction

    function automatic logic cond_legal(logic [2:0] c);
        return (c <= COND_LE);
    endfunction

    // status is {N,V,Z}
    function automatic logic cond_true(logic [2:0] c, logic [2:0] flags);
        logic n;
        logic v;
        logic z;
        logic res;
        n = flags[2];
        v = flags[1];
        z = flags[0];
        case (c)
            COND_AL: res = 1'b1;
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_LT: res = n ^ v;
            COND_LE: res = (n ^ v) | z;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_controller_wait_counter.sv
// Down-counter that stretches memory-access states: loaded with the number
// of extra cycles on entry, decremented while the access is held.
module wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle CPU: fetch, decode and per-instruction
// datapath sequencing. All outputs are registered from the next state so
// they are clean Moore outputs of the state register.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_WAIT  = 0,
    parameter int BRANCH_EN = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic [2:0] status,
    output logic [3:0] vsel,
    output logic [2:0] nsel,
    output logic [1:0] mem_cmd,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_ir,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] pc_sel,
    output logic       halted,
    output logic       illegal,
    output logic [4:0] state
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);
    localparam logic       BR_ON     = (BRANCH_EN != 0);

    state_t state_q;
    state_t state_nxt;
    logic   illegal_q;
    logic   illegal_nxt;
    logic   undef;
    logic   br_taken;
    ctrl_t  ctrl_q;
    logic   wc_load;
    logic   wc_dec;
    logic   wc_done;

    // Control word asserted while the FSM sits in state s. The branch
    // decision is captured on the DECODE->BR transition, so BR's load_pc
    // is still a function of the registered state.
    function automatic ctrl_t ctrl_for(state_t s, logic taken);
        ctrl_t c;
        c = '0;
        case (s)
            RST:     begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            IF1:     begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
            IF2:     begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
            UPD_PC:  begin c.load_pc = 1'b1; c.pc_sel = PC_INC; end
            GET_A:   begin c.nsel = NSEL_RN; c.loada = 1'b1; end
            GET_B:   begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
            ALU:     begin c.loadc = 1'b1; c.loads = 1'b1; end
            WB:      begin c.vsel = VSEL_C; c.nsel = NSEL_RD; c.write = 1'b1; end
            CMP:     begin c.loads = 1'b1; end
            MOV_IMM: begin c.vsel = VSEL_IMM; c.nsel = NSEL_RN; c.write = 1'b1; end
            MOV_B:   begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
            MOV_C:   begin c.asel = 1'b1; c.loadc = 1'b1; end
            MOV_WB:  begin c.vsel = VSEL_C; c.nsel = NSEL_RD; c.write = 1'b1; end
            ADDR:    begin c.bsel = 1'b1; c.loadc = 1'b1; end
            LATCH_A: begin c.load_addr = 1'b1; end
            LD_MEM:  begin c.mem_cmd = MEM_READ; end
            LD_WB:   begin
                c.vsel = VSEL_MDATA; c.nsel = NSEL_RD; c.write = 1'b1; c.mem_cmd = MEM_READ;
            end
            ST_B:    begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            ST_C:    begin c.asel = 1'b1; c.loadc = 1'b1; end
            ST_MEM:  begin c.mem_cmd = MEM_WRITE; end
            BR:      begin
                if (taken) begin
                    c.load_pc = 1'b1;
                    c.pc_sel  = PC_REL;
                end
            end
            BL_LINK: begin
                c.vsel = VSEL_PC; c.nsel = NSEL_RN; c.write = 1'b1;
                c.load_pc = 1'b1; c.pc_sel = PC_REL;
            end
            BX_B:    begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            BX_C:    begin c.asel = 1'b1; c.loadc = 1'b1; end
            BX_PC:   begin c.load_pc = 1'b1; c.pc_sel = PC_REG; end
            HALT:    begin c.halted = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    wait_counter u_wait (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (wc_load),
        .load_val (WAIT_LOAD),
        .dec      (wc_dec),
        .done     (wc_done)
    );

    // Next-state and illegal-flag logic.
    always_comb begin
        state_nxt   = state_q;
        illegal_nxt = illegal_q;
        undef       = 1'b0;
        br_taken    = cond_true(cond, status);
        case (state_q)
            RST:     state_nxt = IF1;
            IF1:     if (wc_done) state_nxt = IF2;
            IF2:     state_nxt = UPD_PC;
            UPD_PC:  state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OPC_ALU, OPC_LDR, OPC_STR: state_nxt = GET_A;
                    OPC_MOV: begin
                        if (op == 2'b10)      state_nxt = MOV_IMM;
                        else if (op == 2'b00) state_nxt = MOV_B;
                        else                  undef = 1'b1;
                    end
                    OPC_HALT: state_nxt = HALT;
                    OPC_B: begin
                        if (BR_ON && (op == 2'b00) && cond_legal(cond)) state_nxt = BR;
                        else                                            undef = 1'b1;
                    end
                    OPC_BL: begin
                        if (BR_ON && (op == 2'b11))      state_nxt = BL_LINK;
                        else if (BR_ON && (op == 2'b00)) state_nxt = BX_B;
                        else                             undef = 1'b1;
                    end
                    default: undef = 1'b1;
                endcase
                if (undef) begin
                    state_nxt   = HALT;
                    illegal_nxt = 1'b1;
                end
            end
            GET_A:   state_nxt = (opcode == OPC_ALU) ? GET_B : ADDR;
            GET_B:   state_nxt = (op == 2'b01) ? CMP : ALU;
            ALU:     state_nxt = WB;
            WB:      state_nxt = IF1;
            CMP:     state_nxt = IF1;
            MOV_IMM: state_nxt = IF1;
            MOV_B:   state_nxt = MOV_C;
            MOV_C:   state_nxt = MOV_WB;
            MOV_WB:  state_nxt = IF1;
            ADDR:    state_nxt = LATCH_A;
            LATCH_A: state_nxt = (opcode == OPC_LDR) ? LD_MEM : ST_B;
            LD_MEM:  if (wc_done) state_nxt = LD_WB;
            LD_WB:   state_nxt = IF1;
            ST_B:    state_nxt = ST_C;
            ST_C:    state_nxt = ST_MEM;
            ST_MEM:  if (wc_done) state_nxt = IF1;
            BR:      state_nxt = IF1;
            BL_LINK: state_nxt = IF1;
            BX_B:    state_nxt = BX_C;
            BX_C:    state_nxt = BX_PC;
            BX_PC:   state_nxt = IF1;
            HALT:    state_nxt = HALT;
            default: state_nxt = HALT;
        endcase
    end

    // Arm the counter on entry to a memory state, count down while held.
    always_comb begin
        wc_load = is_wait_state(state_nxt) && (state_nxt != state_q);
        wc_dec  = is_wait_state(state_q) && !wc_done;
    end

    // State register with the control word registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RST;
            illegal_q <= 1'b0;
            ctrl_q    <= ctrl_for(RST, 1'b0);
        end else begin
            state_q   <= state_nxt;
            illegal_q <= illegal_nxt;
            ctrl_q    <= ctrl_for(state_nxt, br_taken);
        end
    end

    assign vsel      = ctrl_q.vsel;
    assign nsel      = ctrl_q.nsel;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign load_ir   = ctrl_q.load_ir;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign pc_sel    = ctrl_q.pc_sel;
    assign halted    = ctrl_q.halted;
    assign illegal   = illegal_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Expected per-cycle state and
// control words are queued as each instruction is set up and compared
// cycle by cycle as the controller steps.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int A_WAIT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, b_rst_n;
    logic [2:0] a_opcode, a_cond, a_status, b_opcode, b_cond, b_status;
    logic [1:0] a_op, b_op;

    logic [3:0] a_vsel, b_vsel;
    logic [2:0] a_nsel, b_nsel;
    logic [1:0] a_mem_cmd, b_mem_cmd, a_pc_sel, b_pc_sel;
    logic       a_write, a_loada, a_loadb, a_asel, a_bsel, a_loadc, a_loads;
    logic       b_write, b_loada, b_loadb, b_asel, b_bsel, b_loadc, b_loads;
    logic       a_load_pc, a_reset_pc, a_load_ir, a_addr_sel, a_load_addr, a_halted, a_illegal;
    logic       b_load_pc, b_reset_pc, b_load_ir, b_addr_sel, b_load_addr, b_halted, b_illegal;
    logic [4:0] a_state, b_state;

    multicycle_controller #(.MEM_WAIT(A_WAIT), .BRANCH_EN(1)) dut_a (
        .clk(clk), .reset_n(a_rst_n), .opcode(a_opcode), .op(a_op), .cond(a_cond),
        .status(a_status), .vsel(a_vsel), .nsel(a_nsel), .mem_cmd(a_mem_cmd),
        .write(a_write), .loada(a_loada), .loadb(a_loadb), .asel(a_asel), .bsel(a_bsel),
        .loadc(a_loadc), .loads(a_loads), .load_pc(a_load_pc), .reset_pc(a_reset_pc),
        .load_ir(a_load_ir), .addr_sel(a_addr_sel), .load_addr(a_load_addr),
        .pc_sel(a_pc_sel), .halted(a_halted), .illegal(a_illegal), .state(a_state)
    );

    multicycle_controller #(.MEM_WAIT(0), .BRANCH_EN(0)) dut_b (
        .clk(clk), .reset_n(b_rst_n), .opcode(b_opcode), .op(b_op), .cond(b_cond),
        .status(b_status), .vsel(b_vsel), .nsel(b_nsel), .mem_cmd(b_mem_cmd),
        .write(b_write), .loada(b_loada), .loadb(b_loadb), .asel(b_asel), .bsel(b_bsel),
        .loadc(b_loadc), .loads(b_loads), .load_pc(b_load_pc), .reset_pc(b_reset_pc),
        .load_ir(b_load_ir), .addr_sel(b_addr_sel), .load_addr(b_load_addr),
        .pc_sel(b_pc_sel), .halted(b_halted), .illegal(b_illegal), .state(b_state)
    );

    logic [24:0] a_vec, b_vec;
    assign a_vec = {a_vsel, a_nsel, a_mem_cmd, a_write, a_loada, a_loadb, a_asel, a_bsel,
                    a_loadc, a_loads, a_load_pc, a_reset_pc, a_load_ir, a_addr_sel,
                    a_load_addr, a_pc_sel, a_halted, a_illegal};
    assign b_vec = {b_vsel, b_nsel, b_mem_cmd, b_write, b_loada, b_loadb, b_asel, b_bsel,
                    b_loadc, b_loads, b_load_pc, b_reset_pc, b_load_ir, b_addr_sel,
                    b_load_addr, b_pc_sel, b_halted, b_illegal};

    typedef struct packed {
        logic        is_b;
        logic [4:0]  st;
        logic [24:0] vec;
    } exp_t;

    exp_t  sbq[$];
    int    total = 0;
    int    bad = 0;
    int    step = 0;
    string cur_tag = "init";
    bit    cur_b = 1'b0;

    // Expected control word for each state, straight from the state table.
    function automatic logic [24:0] exp_vec(state_t s, bit taken, bit ill);
        logic [3:0] vs;
        logic [2:0] ns;
        logic [1:0] mc, ps;
        logic wr, la, lb, asl, bsl, lc, ls, lpc, rpc, lir, ads, lad, h;
        vs = 4'b0; ns = 3'b0; mc = 2'b0; ps = 2'b0;
        wr = 0; la = 0; lb = 0; asl = 0; bsl = 0; lc = 0; ls = 0;
        lpc = 0; rpc = 0; lir = 0; ads = 0; lad = 0; h = 0;
        case (s)
            RST:     begin rpc = 1; lpc = 1; end
            IF1:     begin ads = 1; mc = 2'b01; end
            IF2:     begin ads = 1; mc = 2'b01; lir = 1; end
            UPD_PC:  begin lpc = 1; ps = 2'b00; end
            GET_A:   begin ns = 3'b100; la = 1; end
            GET_B:   begin ns = 3'b001; lb = 1; end
            ALU:     begin lc = 1; ls = 1; end
            WB:      begin vs = 4'b0001; ns = 3'b010; wr = 1; end
            CMP:     begin ls = 1; end
            MOV_IMM: begin vs = 4'b0100; ns = 3'b100; wr = 1; end
            MOV_B:   begin ns = 3'b001; lb = 1; end
            MOV_C:   begin asl = 1; lc = 1; end
            MOV_WB:  begin vs = 4'b0001; ns = 3'b010; wr = 1; end
            ADDR:    begin bsl = 1; lc = 1; end
            LATCH_A: begin lad = 1; end
            LD_MEM:  begin mc = 2'b01; end
            LD_WB:   begin vs = 4'b1000; ns = 3'b010; wr = 1; mc = 2'b01; end
            ST_B:    begin ns = 3'b010; lb = 1; end
            ST_C:    begin asl = 1; lc = 1; end
            ST_MEM:  begin mc = 2'b11; end
            BR:      begin if (taken) begin lpc = 1; ps = 2'b01; end end
            BL_LINK: begin vs = 4'b0010; ns = 3'b100; wr = 1; lpc = 1; ps = 2'b01; end
            BX_B:    begin ns = 3'b010; lb = 1; end
            BX_C:    begin asl = 1; lc = 1; end
            BX_PC:   begin lpc = 1; ps = 2'b10; end
            HALT:    begin h = 1; end
            default: ;
        endcase
        return {vs, ns, mc, wr, la, lb, asl, bsl, lc, ls, lpc, rpc, lir, ads, lad, ps, h, ill};
    endfunction

    task automatic sb_push(input state_t s, input bit taken, input bit ill);
        exp_t e;
        e.is_b = cur_b;
        e.st   = s;
        e.vec  = exp_vec(s, taken, ill);
        sbq.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [4:0]  got_st;
        logic [24:0] got_v;
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        got_st = e.is_b ? b_state : a_state;
        got_v  = e.is_b ? b_vec : a_vec;
        total++;
        assert (got_st === e.st) else begin
            bad++;
            $error("FAIL %s#%0d state got=%0d want=%0d", cur_tag, step, got_st, e.st);
        end
        total++;
        assert (got_v === e.vec) else begin
            bad++;
            $error("FAIL %s#%0d outputs got=%b want=%b", cur_tag, step, got_v, e.vec);
        end
        step++;
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    // Asynchronous reset pulse, checked while asserted and just after release.
    task automatic do_reset(input bit which, input string tag);
        cur_tag = tag;
        step = 0;
        cur_b = which;
        #2;
        if (which) b_rst_n = 1'b0; else a_rst_n = 1'b0;
        #1;
        sb_push(RST, 0, 0);
        check_now();
        @(negedge clk);
        if (which) b_rst_n = 1'b1; else a_rst_n = 1'b1;
        #1;
        sb_push(RST, 0, 0);
        check_now();
    endtask

    task automatic instr(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                         input logic [2:0] st, input string tag);
        a_opcode = opc;
        a_op     = o;
        a_cond   = c;
        a_status = st;
        cur_tag  = tag;
        cur_b    = 1'b0;
        step     = 0;
        for (int i = 0; i <= A_WAIT; i++) sb_push(IF1, 0, 0);
        sb_push(IF2, 0, 0);
        sb_push(UPD_PC, 0, 0);
        sb_push(DECODE, 0, 0);
    endtask

    initial begin
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_opcode = 3'b0; a_op = 2'b0; a_cond = 3'b0; a_status = 3'b0;
        b_opcode = 3'b001; b_op = 2'b00; b_cond = 3'b000; b_status = 3'b001;
        #1 b_rst_n = 1'b0;

        do_reset(0, "reset");

        instr(3'b101, 2'b00, 3'b000, 3'b000, "add");
        sb_push(GET_A, 0, 0); sb_push(GET_B, 0, 0); sb_push(ALU, 0, 0); sb_push(WB, 0, 0);
        drain();

        instr(3'b101, 2'b01, 3'b000, 3'b000, "cmp");
        sb_push(GET_A, 0, 0); sb_push(GET_B, 0, 0); sb_push(CMP, 0, 0);
        drain();

        instr(3'b110, 2'b10, 3'b000, 3'b000, "mov_imm");
        sb_push(MOV_IMM, 0, 0);
        drain();

        instr(3'b110, 2'b00, 3'b000, 3'b000, "mov_reg");
        sb_push(MOV_B, 0, 0); sb_push(MOV_C, 0, 0); sb_push(MOV_WB, 0, 0);
        drain();

        instr(3'b001, 2'b00, 3'b001, 3'b001, "beq_taken");
        sb_push(BR, 1, 0);
        drain();

        instr(3'b001, 2'b00, 3'b001, 3'b000, "beq_not");
        sb_push(BR, 0, 0);
        drain();

        instr(3'b001, 2'b00, 3'b011, 3'b100, "blt_taken");
        sb_push(BR, 1, 0);
        drain();

        instr(3'b001, 2'b00, 3'b100, 3'b110, "ble_not");
        sb_push(BR, 0, 0);
        drain();

        instr(3'b011, 2'b00, 3'b000, 3'b000, "ldr");
        sb_push(GET_A, 0, 0); sb_push(ADDR, 0, 0); sb_push(LATCH_A, 0, 0);
        for (int i = 0; i <= A_WAIT; i++) sb_push(LD_MEM, 0, 0);
        sb_push(LD_WB, 0, 0);
        drain();

        instr(3'b100, 2'b00, 3'b000, 3'b000, "str");
        sb_push(GET_A, 0, 0); sb_push(ADDR, 0, 0); sb_push(LATCH_A, 0, 0);
        sb_push(ST_B, 0, 0); sb_push(ST_C, 0, 0);
        for (int i = 0; i <= A_WAIT; i++) sb_push(ST_MEM, 0, 0);
        drain();

        instr(3'b010, 2'b11, 3'b111, 3'b000, "bl");
        sb_push(BL_LINK, 0, 0);
        drain();

        instr(3'b010, 2'b00, 3'b000, 3'b000, "bx");
        sb_push(BX_B, 0, 0); sb_push(BX_C, 0, 0); sb_push(BX_PC, 0, 0);
        drain();

        // Load abandoned by reset in the first cycle of its memory wait
        instr(3'b011, 2'b00, 3'b000, 3'b000, "ldr_abort");
        sb_push(GET_A, 0, 0); sb_push(ADDR, 0, 0); sb_push(LATCH_A, 0, 0);
        sb_push(LD_MEM, 0, 0);
        drain();
        do_reset(0, "ldr_abort_rst");

        instr(3'b101, 2'b10, 3'b000, 3'b000, "and_after_rst");
        sb_push(GET_A, 0, 0); sb_push(GET_B, 0, 0); sb_push(ALU, 0, 0); sb_push(WB, 0, 0);
        drain();

        instr(3'b001, 2'b00, 3'b101, 3'b000, "br_badcond");
        for (int i = 0; i < 4; i++) sb_push(HALT, 0, 1);
        drain();
        do_reset(0, "badcond_rst");

        instr(3'b110, 2'b01, 3'b000, 3'b000, "mov_badop");
        for (int i = 0; i < 3; i++) sb_push(HALT, 0, 1);
        drain();
        do_reset(0, "badop_rst");

        instr(3'b111, 2'b00, 3'b000, 3'b000, "halt");
        for (int i = 0; i < 4; i++) sb_push(HALT, 0, 0);
        drain();

        // Branch opcodes are undefined when branching is disabled
        do_reset(1, "nobr_rst");
        cur_tag = "nobr";
        step = 0;
        sb_push(IF1, 0, 0); sb_push(IF2, 0, 0); sb_push(UPD_PC, 0, 0); sb_push(DECODE, 0, 0);
        for (int i = 0; i < 20; i++) sb_push(HALT, 0, 1);
        drain();
        do_reset(1, "nobr_exit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
